soc_system_pio_in_edge: RTL

- Parametrised Avalon-MM slave input port: successor to the fixed 32-bit read-only data PIO.
- Adds:
  - input synchroniser
  - per-bit rising/falling edge capture with write-1-to-clear
  - per-bit interrupt mask and registered IRQ
  - software-triggered snapshot register
- Sits between FPGA fabric status/data signals (AES core flags, done strobes) and the HPS lightweight bridge.

---
 rtl/soc_system_pio_pkg.sv | 14 +
 rtl/soc_system_pio_sync.sv | 35 +++
 rtl/soc_system_pio_in_edge.sv | 119 +++++++++++
 3 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system PIO family: register map and bus width.
`timescale 1ns/1ps
package soc_system_pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE = 3'd2;
  localparam logic [2:0] ADDR_RISE = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_SNAP = 3'd5;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH-wide, STAGES-deep flop synchroniser with async reset; STAGES=0 is a
// straight wire for inputs that are already clk-synchronous.
`timescale 1ns/1ps
module soc_system_pio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset_n;
      assign data_o      = data_i;
    end else begin : g_sync
      logic [WIDTH-1:0] stage_q [STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= data_i;
          for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised data, per-bit edge capture (W1C),
// interrupt mask with registered irq, and a software-triggered snapshot.
`timescale 1ns/1ps
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_s;
  logic [WIDTH-1:0] prev_q;
  logic             primed_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [BUS_W-1:0] readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise, fall;

  soc_system_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (in_port),
    .data_o  (data_s)
  );

  generate
    if (WIDTH < BUS_W) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[BUS_W-1:WIDTH];
    end
  endgenerate

  // primed gates out the spurious edge seen against prev's reset value.
  always_comb begin
    wr    = chipselect & ~write_n;
    wdata = writedata[WIDTH-1:0];
    rise  = data_s & ~prev_q & {WIDTH{primed_q}};
    fall  = ~data_s & prev_q & {WIDTH{primed_q}};

    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    snap_d    = snap_q;
    edge_d    = edge_q;
    if (wr) begin
      case (address)
        ADDR_MASK: mask_d    = wdata;
        ADDR_EDGE: edge_d    = edge_q & ~wdata;
        ADDR_RISE: rise_en_d = wdata;
        ADDR_FALL: fall_en_d = wdata;
        ADDR_SNAP: snap_d    = data_s;
        default:   ;
      endcase
    end
    // A fresh edge overrides a same-cycle W1C on that bit.
    edge_d = edge_d | (rise & rise_en_q) | (fall & fall_en_q);

    irq_d = |(edge_q & mask_q);

    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_s;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_RISE: readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL: readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_SNAP: readdata_d[WIDTH-1:0] = snap_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      mask_q     <= RESET_MASK[WIDTH-1:0];
      edge_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      snap_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= data_s;
      primed_q   <= 1'b1;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      snap_q     <= snap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
